fp_cvt_arbiter: RTL

- Shares one fixed-latency, non-stallable pipelined FP-to-unsigned converter among NUM_REQ requesters.
- Each cycle a round-robin arbiter picks at most one valid request and registers its operand into the converter.
- A matching tag pipeline routes each result back to the originating requester.
- Sits between the SIMT lane request ports and the converter instance.

---
 rtl/fp_cvt_arbiter_pkg.sv | 14 +
 rtl/fp_cvt_arbiter_rr_arbiter.sv | 42 ++++
 rtl/fp_cvt_arbiter.sv | 117 +++++++++++
 3 files changed

// File: rtl/fp_cvt_arbiter_pkg.sv
// Shared types and constants for the FP converter arbiter and related shared FP units.
package fp_cvt_pkg;

    localparam int FP_W            = 32;
    localparam int CVT_LAT_DEFAULT = 3;
    // Tag id is sized for the largest supported requester count (16).
    localparam int TAG_ID_W        = 4;

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } cvt_tag_t;

endpackage

// File: rtl/fp_cvt_arbiter_rr_arbiter.sv
// Reusable round-robin arbiter: one-hot grant plus index, pointer advances on accepted grants only.
module rr_arbiter #(
    parameter int N = 4,
    localparam int IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic             advance,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] index
);

    logic [IDX_W-1:0] ptr;
    logic             found;
    int unsigned      pos;

    // Search begins one past the last winner so every requester gets a turn.
    always_comb begin
        grant = '0;
        index = '0;
        found = 1'b0;
        pos   = 0;
        for (int unsigned k = 0; k < N; k++) begin
            pos = (32'(ptr) + 32'd1 + k) % N;
            if (!found && req[pos]) begin
                found      = 1'b1;
                grant[pos] = 1'b1;
                index      = IDX_W'(pos);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= IDX_W'(N - 1);
        end else if (advance) begin
            ptr <= index;
        end
    end

endmodule

// File: rtl/fp_cvt_arbiter.sv
// Shares one pipelined FP-to-unsigned converter among NUM_REQ requesters with tag-routed results.
// Optional handshake/stall counters are built when FP_ARB_STATS_EN is defined.
module fp_cvt_arbiter
    import fp_cvt_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int CVT_LATENCY = CVT_LAT_DEFAULT,
    parameter int ID_W        = 2
) (
    input  logic                  clk,
    input  logic                  areset,
    input  logic                  enable,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [32*NUM_REQ-1:0] req_data,
    output logic [31:0]           cvt_a,
    input  logic [31:0]           cvt_q,
    output logic [NUM_REQ-1:0]    resp_valid,
    output logic [ID_W-1:0]       resp_id,
    output logic [31:0]           resp_data,
    output logic                  busy
`ifdef FP_ARB_STATS_EN
    ,
    output logic [31:0]           stat_grants,
    output logic [31:0]           stat_stall
`endif
);

    localparam int IDX_W = $clog2(NUM_REQ);
    // Issue tag plus CVT_LATENCY+1 delay stages: the last stage lines up with cvt_q,
    // which trails cvt_a by one extra cycle for the converter's input sample.
    localparam int unsigned DEPTH = CVT_LATENCY + 2;

    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   gnt_idx;
    logic               handshake;
    logic [FP_W-1:0]    sel_data;
    cvt_tag_t           tag_pipe [DEPTH];
    cvt_tag_t           final_tag;

    assign handshake = enable && (req_valid != '0);
    assign req_ready = enable ? grant : '0;
    assign final_tag = tag_pipe[DEPTH-1];

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .clk     (clk),
        .rst_n   (areset),
        .req     (req_valid),
        .advance (handshake),
        .grant   (grant),
        .index   (gnt_idx)
    );

    always_comb begin
        sel_data = req_data[FP_W*int'(gnt_idx) +: FP_W];
    end

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            cvt_a <= '0;
        end else if (handshake) begin
            cvt_a <= sel_data;
        end
    end

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                tag_pipe[k] <= '0;
            end
        end else begin
            tag_pipe[0].valid <= handshake;
            tag_pipe[0].id    <= TAG_ID_W'(gnt_idx);
            for (int unsigned k = 1; k < DEPTH; k++) begin
                tag_pipe[k] <= tag_pipe[k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            resp_valid <= '0;
            resp_id    <= '0;
            resp_data  <= '0;
        end else if (final_tag.valid) begin
            resp_valid <= NUM_REQ'(1) << final_tag.id;
            resp_id    <= final_tag.id[ID_W-1:0];
            resp_data  <= cvt_q;
        end else begin
            resp_valid <= '0;
        end
    end

    always_comb begin
        busy = |resp_valid;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            busy = busy | tag_pipe[k].valid;
        end
    end

`ifdef FP_ARB_STATS_EN
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            stat_grants <= '0;
            stat_stall  <= '0;
        end else begin
            if (handshake && (stat_grants != '1)) begin
                stat_grants <= stat_grants + 32'd1;
            end
            if ((req_valid != '0) && !handshake && (stat_stall != '1)) begin
                stat_stall <= stat_stall + 32'd1;
            end
        end
    end
`endif

endmodule
